llsc_reservation_ctrl: RTL

Controller for the LL/SC link bit and link address.
- Watches LL, SC and plain stores issued from the MEM stage, and store snoops from other bus masters.
- Sequences the architectural LLbit register through its write-enable, write-data and clear inputs.
- Tracks the linked address and decides SC success or failure.
- Sits between the MEM stage and the LLbit register; its result feeds the SC write-back path in WB.

---
 rtl/llsc_reservation_ctrl_pkg.sv | 31 +++
 rtl/llsc_reservation_ctrl_if.sv | 44 ++++
 rtl/llsc_reservation_ctrl_addr_match.sv | 22 ++
 rtl/llsc_reservation_ctrl.sv | 135 +++++++++++++
 4 files changed

// File: rtl/llsc_reservation_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : llsc_reservation_ctrl_pkg
// Brief   : Shared encodings, defaults and helpers for the LL/SC controller
// Revision: 1.0 - initial release
// ============================================================================
package llsc_reservation_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_LL   = 2'b01,
    OP_SC   = 2'b10,
    OP_ST   = 2'b11
  } mem_op_e;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_LINKED = 1'b1
  } llsc_state_e;

  localparam int DEF_LINE_BITS = 2;
  localparam int DEF_TIMEOUT   = 1024;
  localparam int DEF_CNT_W     = 16;

  // Mask keeping only the address bits that take part in a reservation match.
  function automatic logic [31:0] line_mask(input int lb);
    return 32'hFFFF_FFFF << lb;
  endfunction

endpackage
`default_nettype wire

// File: rtl/llsc_reservation_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module  : llsc_reservation_ctrl_if
// Brief   : MEM-stage, snoop and LLbit-register signals of the LL/SC control
// Revision: 1.0 - initial release
// ============================================================================
interface llsc_reservation_ctrl_if;
  import llsc_reservation_ctrl_pkg::*;

  // MEM stage and system events into the controller
  logic        i_mem_valid;
  mem_op_e     i_mem_op;
  logic [31:0] i_mem_addr;
  logic        i_stall;
  logic        i_excpt_in;
  logic        i_eret;
  logic        i_snoop_valid;
  logic [31:0] i_snoop_addr;

  // Reservation state, SC result and LLbit register controls
  logic        o_linked;
  logic [31:0] o_link_addr;
  logic        o_sc_done;
  logic        o_sc_success;
  logic        o_llbit_we;
  logic        o_llbit_wdata;
  logic        o_llbit_clr;

  modport master (
    output i_mem_valid, i_mem_op, i_mem_addr, i_stall, i_excpt_in, i_eret,
           i_snoop_valid, i_snoop_addr,
    input  o_linked, o_link_addr, o_sc_done, o_sc_success, o_llbit_we,
           o_llbit_wdata, o_llbit_clr
  );

  modport slave (
    input  i_mem_valid, i_mem_op, i_mem_addr, i_stall, i_excpt_in, i_eret,
           i_snoop_valid, i_snoop_addr,
    output o_linked, o_link_addr, o_sc_done, o_sc_success, o_llbit_we,
           o_llbit_wdata, o_llbit_clr
  );

endinterface
`default_nettype wire

// File: rtl/llsc_reservation_ctrl_addr_match.sv
`default_nettype none
// ============================================================================
// Module  : llsc_addr_match
// Brief   : Combinational reservation tag compare, low LINE_BITS ignored
// Revision: 1.0 - initial release
// ============================================================================
module llsc_addr_match
  import llsc_reservation_ctrl_pkg::*;
#(
  parameter int LINE_BITS = DEF_LINE_BITS
) (
  input  logic [31:0] i_addr_a,
  input  logic [31:0] i_addr_b,
  output logic        o_match
);

  localparam logic [31:0] c_tag_mask = line_mask(LINE_BITS);

  assign o_match = (((i_addr_a ^ i_addr_b) & c_tag_mask) == 32'd0);

endmodule
`default_nettype wire

// File: rtl/llsc_reservation_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : llsc_reservation_ctrl
// Brief   : LL/SC reservation tracker driving the architectural LLbit register
// Revision: 1.0 - initial release
// ============================================================================
module llsc_reservation_ctrl
  import llsc_reservation_ctrl_pkg::*;
#(
  parameter int LINE_BITS = DEF_LINE_BITS,
  parameter int TIMEOUT   = DEF_TIMEOUT,
  parameter int CNT_W     = DEF_CNT_W
) (
  input logic                    clk,
  input logic                    rst,
  llsc_reservation_ctrl_if.slave bus
);

  localparam logic [31:0]      c_tag_mask = line_mask(LINE_BITS);
  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
  localparam logic [CNT_W-1:0] c_cnt_max  = {CNT_W{1'b1}};

  llsc_state_e      r_state;
  logic [31:0]      r_link_addr;
  logic [CNT_W-1:0] r_cnt;
  logic             r_sc_done;
  logic             r_sc_success;
  logic             r_llbit_we;
  logic             r_llbit_wdata;
  logic             r_llbit_clr;

  llsc_state_e      w_nxt_state;
  logic [31:0]      w_nxt_link_addr;
  logic [CNT_W-1:0] w_nxt_cnt;
  logic             w_nxt_sc_done;
  logic             w_nxt_sc_success;

  logic        w_accept, w_is_ll, w_is_sc, w_is_st;
  logic        w_linked, w_expired, w_flush;
  logic        w_mem_match, w_snoop_match, w_snoop_hit;
  logic [31:0] w_snoop_ref;

  assign w_accept = bus.i_mem_valid && !bus.i_stall;
  assign w_is_ll  = w_accept && (bus.i_mem_op == OP_LL);
  assign w_is_sc  = w_accept && (bus.i_mem_op == OP_SC);
  assign w_is_st  = w_accept && (bus.i_mem_op == OP_ST);
  assign w_linked = (r_state == ST_LINKED);
  assign w_flush  = bus.i_excpt_in || bus.i_eret;
  assign w_expired = (TIMEOUT != 0) && (r_cnt == c_cnt_last);

  // A snoop racing an LL must be checked against the address being linked,
  // otherwise against the address already held.
  assign w_snoop_ref = w_is_ll ? bus.i_mem_addr : r_link_addr;
  assign w_snoop_hit = bus.i_snoop_valid && w_snoop_match;

  llsc_addr_match #(.LINE_BITS(LINE_BITS)) u_mem_match (
    .i_addr_a (bus.i_mem_addr),
    .i_addr_b (r_link_addr),
    .o_match  (w_mem_match)
  );

  llsc_addr_match #(.LINE_BITS(LINE_BITS)) u_snoop_match (
    .i_addr_a (bus.i_snoop_addr),
    .i_addr_b (w_snoop_ref),
    .o_match  (w_snoop_match)
  );

  // Next-state and next-output decode, highest-priority event first.
  always_comb begin
    w_nxt_state      = r_state;
    w_nxt_link_addr  = r_link_addr;
    w_nxt_cnt        = (r_cnt == c_cnt_max) ? r_cnt : r_cnt + CNT_W'(1);
    w_nxt_sc_done    = 1'b0;
    w_nxt_sc_success = 1'b0;

    if (w_flush) begin
      w_nxt_state   = ST_IDLE;
      w_nxt_sc_done = w_is_sc;
    end else if (w_is_sc) begin
      w_nxt_state      = ST_IDLE;
      w_nxt_sc_done    = 1'b1;
      w_nxt_sc_success = w_linked && w_mem_match && !w_snoop_hit && !w_expired;
    end else if (w_is_ll) begin
      if (w_snoop_hit) begin
        w_nxt_state = ST_IDLE;
      end else begin
        w_nxt_state     = ST_LINKED;
        w_nxt_link_addr = bus.i_mem_addr & c_tag_mask;
        w_nxt_cnt       = '0;
      end
    end else if (w_linked && (w_snoop_hit || (w_is_st && w_mem_match))) begin
      w_nxt_state = ST_IDLE;
    end else if (w_linked && w_expired) begin
      w_nxt_state = ST_IDLE;
    end

    // The counter only runs while a reservation is held.
    if (w_nxt_state == ST_IDLE) begin
      w_nxt_cnt = '0;
    end
  end

  // State and output registers; the LLbit strobe fires only on a change of linked.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_link_addr   <= 32'd0;
      r_cnt         <= '0;
      r_sc_done     <= 1'b0;
      r_sc_success  <= 1'b0;
      r_llbit_we    <= 1'b0;
      r_llbit_wdata <= 1'b0;
      r_llbit_clr   <= 1'b0;
    end else begin
      r_state       <= w_nxt_state;
      r_link_addr   <= w_nxt_link_addr;
      r_cnt         <= w_nxt_cnt;
      r_sc_done     <= w_nxt_sc_done;
      r_sc_success  <= w_nxt_sc_success;
      r_llbit_we    <= (w_nxt_state != r_state);
      r_llbit_wdata <= (w_nxt_state != r_state) && (w_nxt_state == ST_LINKED);
      r_llbit_clr   <= w_flush;
    end
  end

  assign bus.o_linked      = w_linked;
  assign bus.o_link_addr   = r_link_addr;
  assign bus.o_sc_done     = r_sc_done;
  assign bus.o_sc_success  = r_sc_success;
  assign bus.o_llbit_we    = r_llbit_we;
  assign bus.o_llbit_wdata = r_llbit_wdata;
  assign bus.o_llbit_clr   = r_llbit_clr;

endmodule
`default_nettype wire
